// File: rtl/onchip_ram_fill_check_if.sv
// onchip_ram_fill_check_if
//   Avalon-MM bus between the fill/check master and the on-chip RAM s1 port.
//   master modport: drives address/clken/chipselect/write/writedata/byteenable,
//                   receives readdata.
//   slave modport : the RAM side, mirror image of the master.
interface onchip_ram_fill_check_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   avm_address;
  logic                avm_clken;
  logic                avm_chipselect;
  logic                avm_write;
  logic [DATA_W-1:0]   avm_writedata;
  logic [DATA_W/8-1:0] avm_byteenable;
  logic [DATA_W-1:0]   avm_readdata;

  modport master (
    output avm_address, avm_clken, avm_chipselect, avm_write,
           avm_writedata, avm_byteenable,
    input  avm_readdata
  );

  modport slave (
    input  avm_address, avm_clken, avm_chipselect, avm_write,
           avm_writedata, avm_byteenable,
    output avm_readdata
  );
endinterface

// File: rtl/onchip_ram_fill_check.sv
// onchip_ram_fill_check
//   Avalon-MM master for RAM bring-up / self-test. Fills a window of words with
//   seed+i, reads the window back and compares, or does both back to back.
// Ports
//   clk, reset      clock, synchronous active-high reset
//   start           one-cycle request, only honoured in IDLE
//   mode            00 fill, 01 check, 1x fill then check
//   base            first word address (window wraps at 2**ADDR_W)
//   length          word count 0..2**ADDR_W
//   seed            pattern seed, word i = seed + i
//   busy            high while filling, checking or draining reads
//   done            one-cycle completion pulse
//   error           at least one mismatch seen in the last check
//   err_count       number of mismatches in the last check
//   first_err_addr  address of the first mismatch
//   avm             Avalon-MM master port to the RAM s1 slave
module onchip_ram_fill_check #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic [ADDR_W-1:0]   base,
  input  logic [ADDR_W:0]     length,
  input  logic [DATA_W-1:0]   seed,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [ADDR_W:0]     err_count,
  output logic [ADDR_W-1:0]   first_err_addr,
  onchip_ram_fill_check_if.master avm
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);
  localparam logic [DATA_W-1:0] D_ONE = DATA_W'(1);
  localparam logic [ADDR_W:0]   C_ONE = (ADDR_W + 1)'(1);

  logic [2:0]              state;
  logic                    then_check;
  logic [ADDR_W-1:0]       base_r;
  logic [ADDR_W:0]         len_r;
  logic [ADDR_W:0]         idx;
  logic [DATA_W-1:0]       seed_r;
  logic [ADDR_W-1:0]       addr_r;
  logic [DATA_W-1:0]       wdata_r;
  logic                    cs_r;
  logic                    we_r;
  logic                    clken_r;

  // One stage per cycle of RAM read latency; the last stage lines up with
  // the readdata belonging to that read.
  logic [READ_LATENCY-1:0] pipe_v;
  logic [ADDR_W-1:0]       pipe_idx [READ_LATENCY];

  logic                    last_word;
  logic                    rd_now;
  logic [READ_LATENCY-1:0] pipe_pend;
  logic [DATA_W-1:0]       exp_data;
  logic                    mismatch;

  assign last_word = (idx == len_r - C_ONE);
  assign rd_now    = cs_r && !we_r;
  // Shifting out the top stage leaves only reads that still need more
  // cycles after this edge; zero means the last compare happens now.
  assign pipe_pend = pipe_v << 1;
  assign exp_data  = seed_r + DATA_W'(pipe_idx[READ_LATENCY-1]);
  assign mismatch  = pipe_v[READ_LATENCY-1] && (avm.avm_readdata != exp_data);

  assign busy = (state == S_FILL) || (state == S_CHECK) || (state == S_DRAIN);
  assign done = (state == S_DONE);

  assign avm.avm_address    = addr_r;
  assign avm.avm_writedata  = wdata_r;
  assign avm.avm_chipselect = cs_r;
  assign avm.avm_write      = we_r;
  assign avm.avm_clken      = clken_r;
  assign avm.avm_byteenable = cs_r ? '1 : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      then_check     <= 1'b0;
      base_r         <= '0;
      len_r          <= '0;
      idx            <= '0;
      seed_r         <= '0;
      addr_r         <= '0;
      wdata_r        <= '0;
      cs_r           <= 1'b0;
      we_r           <= 1'b0;
      clken_r        <= 1'b0;
      error          <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      pipe_v         <= '0;
      for (int j = 0; j < READ_LATENCY; j++) pipe_idx[j] <= '0;
    end else begin
      pipe_v      <= (pipe_v << 1) | READ_LATENCY'(rd_now);
      pipe_idx[0] <= idx[ADDR_W-1:0];
      for (int j = 1; j < READ_LATENCY; j++) pipe_idx[j] <= pipe_idx[j-1];

      // first_err_addr is only captured while error is still clear.
      if (mismatch) begin
        err_count <= err_count + C_ONE;
        error     <= 1'b1;
        if (!error) first_err_addr <= base_r + pipe_idx[READ_LATENCY-1];
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            then_check     <= mode[1];
            base_r         <= base;
            len_r          <= length;
            seed_r         <= seed;
            idx            <= '0;
            error          <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            if (length == '0) begin
              state <= S_DONE;
            end else if (mode == 2'b01) begin
              state   <= S_CHECK;
              addr_r  <= base;
              cs_r    <= 1'b1;
              we_r    <= 1'b0;
              clken_r <= 1'b1;
            end else begin
              state   <= S_FILL;
              addr_r  <= base;
              wdata_r <= seed;
              cs_r    <= 1'b1;
              we_r    <= 1'b1;
              clken_r <= 1'b1;
            end
          end
        end
        S_FILL: begin
          if (last_word) begin
            if (then_check) begin
              state  <= S_CHECK;
              idx    <= '0;
              addr_r <= base_r;
              we_r   <= 1'b0;
            end else begin
              state   <= S_DONE;
              cs_r    <= 1'b0;
              we_r    <= 1'b0;
              clken_r <= 1'b0;
            end
          end else begin
            idx     <= idx + C_ONE;
            addr_r  <= addr_r + A_ONE;
            wdata_r <= wdata_r + D_ONE;
          end
        end
        S_CHECK: begin
          if (last_word) begin
            state <= S_DRAIN;
            cs_r  <= 1'b0;
          end else begin
            idx    <= idx + C_ONE;
            addr_r <= addr_r + A_ONE;
          end
        end
        S_DRAIN: begin
          if (pipe_pend == '0) begin
            state   <= S_DONE;
            clken_r <= 1'b0;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
